// File: rtl/psum_accum_sfu_if.sv
// ----------------------------------------------------------------------------
// psum_accum_sfu_if
//   Bundles the single-port PMEM SRAM port used by psum_accum_sfu.
//   master : the accumulate stage (drives address/data/enables, reads OP_q)
//   slave  : the SRAM (or its model), returns OP_q one cycle after a read
// Signals
//   OP_q    PMEM read data, valid the cycle after a read
//   OP_d    PMEM write data
//   OP_addr PMEM address
//   OP_cen  chip enable, active low
//   OP_wen  write enable, active low (0 = write)
// ----------------------------------------------------------------------------
interface psum_accum_sfu_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int ADDR_W  = 9
);
    logic [psum_bw*col-1:0] OP_q;
    logic [psum_bw*col-1:0] OP_d;
    logic [ADDR_W-1:0]      OP_addr;
    logic                   OP_cen;
    logic                   OP_wen;

    modport master (
        input  OP_q,
        output OP_d,
        output OP_addr,
        output OP_cen,
        output OP_wen
    );

    modport slave (
        output OP_q,
        input  OP_d,
        input  OP_addr,
        input  OP_cen,
        input  OP_wen
    );
endinterface

// File: rtl/psum_accum_sfu.sv
// ----------------------------------------------------------------------------
// psum_accum_sfu
//   Accumulate / special-function stage behind mac_array. Rows of partial sums
//   are captured into a small input FIFO and read-modify-written into the PMEM
//   SRAM. A first pass overwrites PMEM (1 row/cycle); later passes read, add
//   with per-lane saturation and write back (1 row per 2 cycles). On the last
//   pass a ReLU is applied before the write.
// Ports
//   clk, reset      clock (posedge) and asynchronous active-low reset
//   start           1-cycle pulse starting a pass (ignored while busy)
//   first_pass      sampled at start: overwrite, no read/add
//   last_pass       sampled at start: apply ReLU before write
//   base_addr, len  sampled at start: PMEM address of row 0, rows in the pass
//   in_psum         row from mac_array, lane i = bits [i*psum_bw +: psum_bw]
//   in_valid        in_psum valid (no backpressure upstream)
//   busy            pass in progress
//   done            1-cycle pulse after the final row is written
//   ovf_err         sticky, a row was dropped (FIFO full or valid while idle)
//   pmem            PMEM SRAM port (see psum_accum_sfu_if)
// ----------------------------------------------------------------------------
module psum_accum_sfu #(
    parameter int psum_bw    = 16,
    parameter int col        = 8,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   first_pass,
    input  logic                   last_pass,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W-1:0]      len,
    input  logic [psum_bw*col-1:0] in_psum,
    input  logic                   in_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf_err,
    psum_accum_sfu_if.master       pmem
);

    localparam int ROW_W = psum_bw * col;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    // Per-lane saturating add of head and (optionally) the PMEM word, then
    // optional ReLU. With accumulate=0 the PMEM word is ignored entirely.
    function automatic logic [ROW_W-1:0] lane_fn(
        input logic [ROW_W-1:0] head,
        input logic [ROW_W-1:0] acc,
        input logic             accumulate,
        input logic             relu
    );
        logic [ROW_W-1:0]   res;
        logic [psum_bw-1:0] h;
        logic [psum_bw-1:0] a;
        logic [psum_bw:0]   sum;
        logic [psum_bw-1:0] r;
        res = {ROW_W{1'b0}};
        for (int i = 0; i < col; i++) begin
            h = head[i*psum_bw +: psum_bw];
            if (accumulate) begin
                a = acc[i*psum_bw +: psum_bw];
            end else begin
                a = {psum_bw{1'b0}};
            end
            // One guard bit: the two top bits disagree exactly on overflow.
            sum = {h[psum_bw-1], h} + {a[psum_bw-1], a};
            if (sum[psum_bw] != sum[psum_bw-1]) begin
                r = sum[psum_bw] ? LANE_MIN : LANE_MAX;
            end else begin
                r = sum[psum_bw-1:0];
            end
            if (relu && r[psum_bw-1]) begin
                r = {psum_bw{1'b0}};
            end else begin
                r = r;
            end
            res[i*psum_bw +: psum_bw] = r;
        end
        return res;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [ROW_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              start_acc_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              empty_s;
    logic              full_s;
    logic [ROW_W-1:0]  head_s;
    logic [ADDR_W-1:0] row_addr_s;
    logic              last_row_s;
    logic              op_cen_s;
    logic              op_wen_s;
    logic [ADDR_W-1:0] op_addr_s;
    logic [ROW_W-1:0]  op_d_s;

    assign empty_s     = (count_q == {CNT_W{1'b0}});
    assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    assign head_s      = mem_q[rd_ptr_q];
    assign row_addr_s  = base_q + cnt_q;
    assign last_row_s  = (cnt_q == (len_q - ADDR_W'(1)));
    assign start_acc_s = (state_q == S_IDLE) && start;

    // Pass sequencing and the combinational PMEM command.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        last_d    = last_q;
        pop_s     = 1'b0;
        op_cen_s  = 1'b1;
        op_wen_s  = 1'b1;
        op_addr_s = {ADDR_W{1'b0}};
        op_d_s    = {ROW_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len;
                    first_d = first_pass;
                    last_d  = last_pass;
                    cnt_d   = {ADDR_W{1'b0}};
                    state_d = (len == {ADDR_W{1'b0}}) ? S_FIN : S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (empty_s) begin
                    state_d = S_RD;
                end else if (first_q) begin
                    // Overwrite pass: no read, write the head straight away.
                    op_cen_s  = 1'b0;
                    op_wen_s  = 1'b0;
                    op_addr_s = row_addr_s;
                    op_d_s    = lane_fn(head_s, {ROW_W{1'b0}}, 1'b0, last_q);
                    pop_s     = 1'b1;
                    if (last_row_s) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = S_RD;
                    end
                end else begin
                    op_cen_s  = 1'b0;
                    op_wen_s  = 1'b1;
                    op_addr_s = row_addr_s;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                // OP_q holds the word read in the previous (RD) cycle.
                op_cen_s  = 1'b0;
                op_wen_s  = 1'b0;
                op_addr_s = row_addr_s;
                op_d_s    = lane_fn(head_s, pmem.OP_q, 1'b1, last_q);
                pop_s     = 1'b1;
                if (last_row_s) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // Input FIFO bookkeeping and drop detection; a full FIFO still accepts
    // a push in a cycle that also pops.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_s   = in_valid && busy_q && (!full_s || pop_s);
        drop_s   = in_valid && !push_s;
        if (start_acc_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = in_psum;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_s && pop_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end
        // A drop in the same cycle as an accepted start still counts.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (start_acc_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, pass context and FIFO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            base_q   <= {ADDR_W{1'b0}};
            len_q    <= {ADDR_W{1'b0}};
            cnt_q    <= {ADDR_W{1'b0}};
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: {ROW_W{1'b0}}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ovf_err      = ovf_q;
    assign pmem.OP_cen  = op_cen_s;
    assign pmem.OP_wen  = op_wen_s;
    assign pmem.OP_addr = op_addr_s;
    assign pmem.OP_d    = op_d_s;

endmodule
